// File: rtl/uart_mem_port.sv
// UART access controller behind the MEM stage.
// Drives the CPLD rdn/wrn handshake over the low byte of RAM1.
module uart_mem_port #(
  parameter logic [15:0] DATA_ADDR     = 16'hBF00,
  parameter logic [15:0] STAT_ADDR     = 16'hBF01,
  parameter int          WR_LOW_CYCLES = 2,
  parameter int          RD_LOW_CYCLES = 2,
  parameter int          SETTLE_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        uart_sel,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  input  logic [7:0]  bus_din,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready,
  output logic        rdn,
  output logic        wrn
);

  typedef enum logic [2:0] {
    IDLE,
    WR_LOW,
    WR_SETTLE,
    WR_WAIT,
    RD_WAIT,
    RD_LOW,
    DONE
  } state_t;

  localparam logic [7:0] WR_N = 8'(WR_LOW_CYCLES - 1);
  localparam logic [7:0] RD_N = 8'(RD_LOW_CYCLES - 1);
  localparam logic [7:0] ST_N = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] tbre_q;
  logic [1:0] tsre_q;
  logic [1:0] dr_q;
  logic       tbre_s;
  logic       tsre_s;
  logic       data_ready_s;
  logic       is_data;
  logic       is_stat;
  logic       sel;
  logic       unused_hi;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tbre_q <= '0;
      tsre_q <= '0;
      dr_q   <= '0;
    end else begin
      tbre_q <= {tbre_q[0], tbre};
      tsre_q <= {tsre_q[0], tsre};
      dr_q   <= {dr_q[0], data_ready};
    end
  end

  assign tbre_s       = tbre_q[1];
  assign tsre_s       = tsre_q[1];
  assign data_ready_s = dr_q[1];

  assign is_data  = (addr == DATA_ADDR);
  assign is_stat  = (addr == STAT_ADDR);
  assign sel      = (mem_read | mem_write) && (is_data || is_stat);
  assign uart_sel = sel;
  assign busy     = sel && (state != DONE);
  assign unused_hi = ^wdata[15:8];

  // A request with both mem_read and mem_write set is served as a read.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      rdn      <= 1'b1;
      wrn      <= 1'b1;
      bus_oe   <= 1'b0;
      bus_dout <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel) begin
            unique case (1'b1)
              mem_read && is_stat: begin
                rdata <= {14'b0, data_ready_s, tbre_s & tsre_s};
                state <= DONE;
              end
              mem_read && is_data: begin
                state <= RD_WAIT;
              end
              !mem_read && is_data: begin
                wrn      <= 1'b0;
                bus_oe   <= 1'b1;
                bus_dout <= wdata[7:0];
                cnt      <= WR_N;
                state    <= WR_LOW;
              end
              !mem_read && is_stat: begin
                state <= DONE;
              end
            endcase
          end
        end
        WR_LOW: begin
          if (cnt == 8'd0) begin
            wrn   <= 1'b1;
            cnt   <= ST_N;
            state <= WR_SETTLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WR_SETTLE: begin
          if (cnt == 8'd0) begin
            bus_oe <= 1'b0;
            state  <= WR_WAIT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WR_WAIT: begin
          if (tbre_s && tsre_s) state <= DONE;
        end
        RD_WAIT: begin
          if (data_ready_s) begin
            rdn   <= 1'b0;
            cnt   <= RD_N;
            state <= RD_LOW;
          end
        end
        RD_LOW: begin
          if (cnt == 8'd0) begin
            rdn   <= 1'b1;
            rdata <= {8'h00, bus_din};
            state <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_port.sv
// Directed bench for uart_mem_port.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_uart_mem_port;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] rdata;
  logic        busy;
  logic        uart_sel;
  logic [7:0]  bus_dout;
  logic        bus_oe;
  logic [7:0]  bus_din = '0;
  logic        tbre = 1'b0;
  logic        tsre = 1'b0;
  logic        data_ready = 1'b0;
  logic        rdn;
  logic        wrn;

  int errors = 0;
  int checks = 0;

  uart_mem_port dut (
    .CLK(CLK),
    .RST(RST),
    .addr(addr),
    .wdata(wdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .rdata(rdata),
    .busy(busy),
    .uart_sel(uart_sel),
    .bus_dout(bus_dout),
    .bus_oe(bus_oe),
    .bus_din(bus_din),
    .tbre(tbre),
    .tsre(tsre),
    .data_ready(data_ready),
    .rdn(rdn),
    .wrn(wrn)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset;
    idle_cycles(2);
    @(negedge CLK);
    checks++;
    if ({wrn, rdn, bus_oe, rdata, bus_dout} !== {3'b110, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset_vals got wrn=%b rdn=%b oe=%b rdata=%h dout=%h",
               wrn, rdn, bus_oe, rdata, bus_dout);
    end
    RST = 1'b1;
    next_cycle();
    addr = 16'hBF00;
    wdata = 16'h00AA;
    mem_write = 1'b1;
    idle_cycles(2);
    @(negedge CLK);
    checks++;
    if (wrn !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_wrn got %b want 0", wrn);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({wrn, rdn, bus_oe, rdata} !== {3'b110, 16'h0}) begin
      errors++;
      $display("FAIL rst_async got wrn=%b rdn=%b oe=%b rdata=%h want 1 1 0 0000",
               wrn, rdn, bus_oe, rdata);
    end
    mem_write = 1'b0;
    next_cycle();
    RST = 1'b1;
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({busy, uart_sel, wrn} !== 3'b001) begin
      errors++;
      $display("FAIL rst_idle got busy=%b sel=%b wrn=%b want 0 0 1",
               busy, uart_sel, wrn);
    end
    next_cycle();
    addr = 16'hBF01;
    mem_write = 1'b1;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle_stall got busy=%b want 1", busy);
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_done got busy=%b want 0", busy);
    end
    next_cycle();
    mem_write = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_write;
    logic ewrn;
    logic eoe;
    logic ebusy;
    tbre = 1'b0;
    tsre = 1'b0;
    idle_cycles(3);
    addr = 16'hBF00;
    wdata = 16'h1234;
    mem_write = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 9) begin
        tbre = 1'b1;
        tsre = 1'b1;
      end
      @(negedge CLK);
      ewrn  = !(c >= 1 && c <= 2);
      eoe   = (c >= 1 && c <= 5);
      ebusy = (c < 12);
      checks++;
      if (wrn !== ewrn || rdn !== 1'b1) begin
        errors++;
        $display("FAIL wr_strobe c=%0d got wrn=%b rdn=%b want wrn=%b rdn=1",
                 c, wrn, rdn, ewrn);
      end
      checks++;
      if (bus_oe !== eoe) begin
        errors++;
        $display("FAIL wr_oe c=%0d got %b want %b", c, bus_oe, eoe);
      end
      if (eoe) begin
        checks++;
        if (bus_dout !== 8'h34) begin
          errors++;
          $display("FAIL wr_dout c=%0d got %h want 34", c, bus_dout);
        end
      end
      checks++;
      if (busy !== ebusy) begin
        errors++;
        $display("FAIL wr_busy c=%0d got %b want %b", c, busy, ebusy);
      end
      next_cycle();
    end
    mem_write = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_read;
    logic erdn;
    logic ebusy;
    data_ready = 1'b0;
    bus_din = 8'h5A;
    idle_cycles(3);
    addr = 16'hBF00;
    mem_read = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      if (c == 10) data_ready = 1'b1;
      @(negedge CLK);
      erdn  = !(c >= 13 && c <= 14);
      ebusy = (c < 15);
      checks++;
      if (rdn !== erdn || wrn !== 1'b1 || bus_oe !== 1'b0) begin
        errors++;
        $display("FAIL rd_strobe c=%0d got rdn=%b wrn=%b oe=%b want rdn=%b 1 0",
                 c, rdn, wrn, bus_oe, erdn);
      end
      checks++;
      if (busy !== ebusy) begin
        errors++;
        $display("FAIL rd_busy c=%0d got %b want %b", c, busy, ebusy);
      end
      if (c == 15) begin
        checks++;
        if (rdata !== 16'h005A) begin
          errors++;
          $display("FAIL rd_data got %h want 005a", rdata);
        end
      end
      next_cycle();
    end
    mem_read = 1'b0;
    data_ready = 1'b0;
    idle_cycles(2);
  endtask

  task automatic status_read(input logic [15:0] exp, input string nm);
    addr = 16'hBF01;
    mem_read = 1'b1;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_stall got busy=%b want 1", nm, busy);
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || rdata !== exp) begin
      errors++;
      $display("FAIL %s got busy=%b rdata=%h want 0 %h", nm, busy, rdata, exp);
    end
    next_cycle();
    mem_read = 1'b0;
  endtask

  task automatic test_status;
    tbre = 1'b1;
    tsre = 1'b1;
    data_ready = 1'b0;
    idle_cycles(3);
    status_read(16'h0001, "stat_tx");
    data_ready = 1'b1;
    idle_cycles(2);
    status_read(16'h0003, "stat_rx");
    idle_cycles(1);
  endtask

  task automatic test_non_uart;
    addr = 16'h8000;
    mem_read = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if ({uart_sel, busy, rdn, wrn} !== 4'b0011 || rdata !== 16'h0003) begin
        errors++;
        $display("FAIL non_uart c=%0d got sel=%b busy=%b rdn=%b wrn=%b rdata=%h",
                 c, uart_sel, busy, rdn, wrn, rdata);
      end
      next_cycle();
    end
    mem_read = 1'b0;
    addr = 16'hBF01;
    mem_write = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if (busy !== (c == 0) || wrn !== 1'b1 || uart_sel !== 1'b1) begin
        errors++;
        $display("FAIL stat_write c=%0d got busy=%b wrn=%b sel=%b",
                 c, busy, wrn, uart_sel);
      end
      next_cycle();
    end
    mem_write = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_back_to_back;
    tbre = 1'b1;
    tsre = 1'b1;
    data_ready = 1'b1;
    bus_din = 8'hC3;
    idle_cycles(3);
    addr = 16'hBF00;
    wdata = 16'h0077;
    mem_write = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 8) begin
        mem_write = 1'b0;
        mem_read = 1'b1;
      end
      @(negedge CLK);
      if (c == 6 || c == 7 || c == 8 || c == 12) begin
        checks++;
        if (busy !== (c == 6 || c == 8)) begin
          errors++;
          $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, (c == 6 || c == 8));
        end
      end
      if (c == 10 || c == 12) begin
        checks++;
        if (rdn !== (c == 12)) begin
          errors++;
          $display("FAIL b2b_rdn c=%0d got %b want %b", c, rdn, (c == 12));
        end
      end
      if (c == 12) begin
        checks++;
        if (rdata !== 16'h00C3) begin
          errors++;
          $display("FAIL b2b_rdata got %h want 00c3", rdata);
        end
      end
      next_cycle();
    end
    mem_read = 1'b0;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_status();
    test_non_uart();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
